sdram_rr_arb: RTL

//  N-port round-robin arbiter sharing one SDRAM controller command port among NPORTS requesters.

---
 rtl/sdram_rr_arb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sdram_rr_arb.sv
// Round-robin arbiter sharing one SDRAM controller command port among NPORTS
// requesters, with one outstanding transaction and a response watchdog.
module sdram_rr_arb #(
  parameter int unsigned NPORTS  = 4,
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned WEW    = DW / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORTS-1:0]       p_rd,
  input  logic [NPORTS*WEW-1:0]   p_wr,
  input  logic [NPORTS*AW-1:0]    p_addr,
  input  logic [NPORTS*DW-1:0]    p_wdata,
  output logic [NPORTS-1:0]       p_rdy,
  output logic [NPORTS-1:0]       p_rvalid,
  output logic [NPORTS-1:0]       p_wvalid,
  output logic [NPORTS-1:0]       p_error,
  output logic [DW-1:0]           p_rdata,
  output logic                    c_rd,
  output logic [WEW-1:0]          c_wr,
  output logic [AW-1:0]           c_addr,
  output logic [DW-1:0]           c_wdata,
  input  logic                    c_rdy,
  input  logic                    c_rvalid,
  input  logic                    c_wvalid,
  input  logic                    c_error,
  input  logic [DW-1:0]           c_rdata,
  output logic                    timeout_flag
);

  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [TW-1:0]   wdog, wdog_nxt;
  logic            flag_nxt;

  logic [NPORTS-1:0] req;
  logic [WEW-1:0]    wr_a    [NPORTS];
  logic [AW-1:0]     addr_a  [NPORTS];
  logic [DW-1:0]     wdata_a [NPORTS];

  logic              any_req;
  logic [PW-1:0]     win;
  logic [PW-1:0]     owner_inc;
  logic              resp;

  // Unpack the flat per-port buses and form each port's request
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign wr_a[g]    = p_wr[g*WEW +: WEW];
    assign addr_a[g]  = p_addr[g*AW +: AW];
    assign wdata_a[g] = p_wdata[g*DW +: DW];
    assign req[g]     = p_rd[g] | (|wr_a[g]);
  end

  assign owner_inc = (owner == PW'(NPORTS - 1)) ? '0 : owner + PW'(1);
  assign resp      = c_rvalid | c_wvalid | c_error;

  // Round-robin search: first requester at or after ptr, wrapping
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_w;
    any_req = 1'b0;
    win     = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx   = (32'(ptr) + k) % NPORTS;
      idx_w = PW'(idx);
      if (!any_req && req[idx_w]) begin
        any_req = 1'b1;
        win     = idx_w;
      end
    end
  end

  // State, pointer, owner, watchdog and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      owner        <= '0;
      wdog         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      owner        <= owner_nxt;
      wdog         <= wdog_nxt;
      timeout_flag <= flag_nxt;
    end
  end

  // Next-state and output decode; responses while idle are dropped
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    wdog_nxt  = wdog;
    flag_nxt  = timeout_flag;
    p_rdy     = '0;
    p_rvalid  = '0;
    p_wvalid  = '0;
    p_error   = '0;
    p_rdata   = '0;
    c_rd      = 1'b0;
    c_wr      = '0;
    c_addr    = '0;
    c_wdata   = '0;

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          c_rd    = p_rd[win];
          c_wr    = wr_a[win];
          c_addr  = addr_a[win];
          c_wdata = wdata_a[win];
          if (c_rdy) begin
            p_rdy[win] = 1'b1;
            owner_nxt  = win;
            wdog_nxt   = '0;
            state_nxt  = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        p_rvalid[owner] = c_rvalid;
        p_wvalid[owner] = c_wvalid;
        p_error[owner]  = c_error;
        if (c_rvalid) p_rdata = c_rdata;
        if (resp) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = owner_inc;
        end else if (wdog == TW'(TIMEOUT - 1)) begin
          p_error[owner] = 1'b1;
          flag_nxt       = 1'b1;
          state_nxt      = ST_IDLE;
          ptr_nxt        = owner_inc;
        end else begin
          wdog_nxt = wdog + TW'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
